// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and entry types for the instruction fetch queue
package fetch_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int ILEN      = 32;

    typedef logic [ILEN-1:0] instr_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] pc;
        instr_t               instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry {pc, instr} register file with split write ports and async read
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             pc_we_i,
    input  logic [AW-1:0]    pc_waddr_i,
    input  logic [WIDTH-1:0] pc_wdata_i,
    input  logic             instr_we_i,
    input  logic [AW-1:0]    instr_waddr_i,
    input  instr_t           instr_wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rd_pc_o,
    output instr_t           rd_instr_o
);
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        instr_t           instr;
    } entry_t;

    entry_t mem_q [DEPTH];

    // PC is captured at request time and the instruction at response time, usually into different slots
    always_ff @(posedge clk) begin
        if (pc_we_i) mem_q[pc_waddr_i].pc <= pc_wdata_i;
        if (instr_we_i) mem_q[instr_waddr_i].instr <= instr_wdata_i;
    end

    assign rd_pc_o    = mem_q[raddr_i].pc;
    assign rd_instr_o = mem_q[raddr_i].instr;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order imem fetch with PC handshake, response queue and flush discard tracking
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    output logic             pc_advance,
    input  logic             flush,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [ILEN-1:0]  imem_rsp_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [ILEN-1:0]  dec_instr,
    output logic [WIDTH-1:0] dec_pc
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int PW1 = PW + 1;
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW:0]   MAX_OUT_P = PW1'(MAX_OUT);

    logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d, discard_q, discard_d;
    logic [PW-1:0] reserved, outstanding;
    logic [PW:0]   in_flight;
    logic          rsp_drop, rsp_fill, pop;
    logic [WIDTH-1:0] mem_pc;
    instr_t           mem_instr;

    assign reserved       = alloc_q - rd_q;
    assign outstanding    = alloc_q - fill_q;
    assign in_flight      = {1'b0, outstanding} + {1'b0, discard_q};
    assign imem_req_valid = rst && !flush && reserved < DEPTH_P && in_flight < MAX_OUT_P;
    assign imem_addr      = PC;
    assign pc_advance     = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && discard_q != '0;
    assign rsp_fill       = imem_rsp_valid && discard_q == '0 && outstanding != '0 && !flush;
    assign dec_valid      = fill_q != rd_q && !flush;
    assign pop            = dec_valid && dec_ready;
    assign dec_pc         = rst ? mem_pc : '0;
    assign dec_instr      = rst ? mem_instr : '0;

    // Flush rewinds all pointers and turns every in-flight fetch into a pending discard
    always_comb begin
        alloc_d   = flush ? '0 : alloc_q + PW'(pc_advance);
        fill_d    = flush ? '0 : fill_q + PW'(rsp_fill);
        rd_d      = flush ? '0 : rd_q + PW'(pop);
        discard_d = flush ? discard_q + outstanding - PW'(imem_rsp_valid && (discard_q != '0 || outstanding != '0))
                          : discard_q - PW'(rsp_drop);
    end

    // Pointer and discard state; reset abandons anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q   <= '0;
            fill_q    <= '0;
            rd_q      <= '0;
            discard_q <= '0;
        end else begin
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            rd_q      <= rd_d;
            discard_q <= discard_d;
        end
    end

    // A response with nothing outstanding and nothing to discard is a memory protocol error
    always_ff @(posedge clk) begin
        if (rst) assert (!(imem_rsp_valid && outstanding == '0 && discard_q == '0));
    end

    fetch_queue_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk           (clk),
        .pc_we_i       (pc_advance),
        .pc_waddr_i    (alloc_q[AW-1:0]),
        .pc_wdata_i    (PC),
        .instr_we_i    (rsp_fill),
        .instr_waddr_i (fill_q[AW-1:0]),
        .instr_wdata_i (imem_rsp_data),
        .raddr_i       (rd_q[AW-1:0]),
        .rd_pc_o       (mem_pc),
        .rd_instr_o    (mem_instr)
    );
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch stage directly downstream of the PC register / next-PC mux.
- Takes the current PC and issues in-order requests to instruction memory.
- Tells the PC register when it may advance.
- Buffers returned instructions with their PCs in a small queue.
- Presents them to decode over a valid/ready handshake.
- Branch redirect (flush) discards queued and in-flight fetches.

Parameters:
WIDTH, 32, address/PC width
DEPTH, 4, queue entries; power of 2, >= 2
MAX_OUT, 2, maximum imem requests accepted but not yet answered; 1 <= MAX_OUT <= DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
PC  in  WIDTH  current PC from PC register
pc_advance  out  1  PC register loads next_PC this cycle
flush  in  1  redirect: drop queue contents and in-flight fetches
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_addr  out  WIDTH  fetch address (= PC)
imem_rsp_valid  in  1  instruction word returning, in request order
imem_rsp_data  in  32  instruction word
dec_valid  out  1  decode entry valid
dec_ready  in  1  decode accepts entry
dec_instr  out  32  instruction to decode
dec_pc  out  WIDTH  PC of dec_instr

Behaviour:
- Storage: DEPTH entries {pc, instr}. Three pointers, each log2(DEPTH)+1 bits, wrapping naturally:
  - alloc: next slot reserved by an accepted request
  - fill: next slot written by a response
  - rd: head presented to decode
- Counters: reserved = alloc - rd; outstanding = alloc - fill; discard = register, 0..MAX_OUT.
- Request issue, combinational: imem_req_valid = rst && !flush && reserved < DEPTH && (outstanding + discard) < MAX_OUT.
- imem_addr = PC.
- Acceptance: pc_advance = imem_req_valid && imem_req_ready. On acceptance, PC is written to slot[alloc] and alloc increments.
- Response handling:
  - If discard > 0, imem_rsp_valid decrements discard; nothing is written.
  - Otherwise the response writes instr into slot[fill] and fill increments.
- Decode output:
  - dec_valid = (fill != rd) && !flush.
  - dec_instr and dec_pc come from slot[rd].
  - Pop on dec_valid && dec_ready; rd increments.
- Latency:
  - Response in cycle N gives dec_valid in cycle N+1.
  - With single-cycle imem, request in cycle 0 gives dec_valid in cycle 2.
- Flush, registered effect:
  - alloc, fill and rd are set to 0.
  - discard <= discard + outstanding - (imem_rsp_valid this cycle ? 1 : 0).
  - In the flush cycle: no request, no pop, dec_valid = 0.
  - A response arriving in the flush cycle counts as discarded.
  - Issue resumes the next cycle, subject to the discard limit.
- Simultaneous events:
  - Request, response and pop in the same cycle are all legal and apply together.
  - Full queue (reserved == DEPTH) with a pop in the same cycle: no request this cycle. imem_req_valid is not a function of dec_ready.
- Protocol errors: imem_rsp_valid with outstanding == 0 and discard == 0 is ignored. Flag it with an assertion.
- Reset (rst low, any time, asynchronous):
  - pointers = 0, discard = 0.
  - imem_req_valid = 0, pc_advance = 0, dec_valid = 0.
  - dec_instr and dec_pc = 0.
  - Storage contents are don't-care.
  - Reset mid-transaction abandons in-flight responses. The memory is reset alongside.

Decomposition:
- Shared package fetch_pkg:
  - WIDTH default
  - instr_t (32-bit)
  - fetch_entry_t {pc, instr}
  - ILEN = 32
- One sub-module, fetch_queue_mem: DEPTH x fetch_entry_t register array.
  - Separate pc and instr write ports.
  - Async read at rd.
- Pointer, counter and flush logic stay in instr_fetch_queue.

Test Plan:
- Reset release, imem ready=1, 1-cycle response, dec_ready=1, PC 0x0,0x4,0x8 -> dec_pc sequence 0x0,0x4,0x8 with matching instrs; first dec_valid 2 cycles after first request.
- dec_ready=0, imem always ready -> exactly 4 requests accepted (pc_advance 4 times), then imem_req_valid=0; queue holds PCs 0x0..0xC.
- MAX_OUT=2, imem accepts but delays responses 5 cycles -> never more than 2 accepted without a response; pc_advance low while 2 outstanding.
- Flush with 2 outstanding, new PC=0x100 -> next 2 responses dropped (never seen on dec); first dec_pc after flush = 0x100.
- Flush in the same cycle as a response, with 1 outstanding -> discard stays 0, that response dropped, dec_valid=0 that cycle, next fetch from new PC delivered normally.
- rst asserted mid-stream with 2 queued -> dec_valid, imem_req_valid and pc_advance fall immediately (async); after release, fetch restarts from PC with an empty queue.
